// File: rtl/i2c_slave_reg.sv
// I2C register-file slave: 7-bit address, byte pointer, burst writes, local read-back port.
// Define I2C_SLV_READ_EN to add master-read support (TX / RX_ACK states); the default build is write-only.
module i2c_slave_reg #(
  parameter logic [6:0] DEV_ADDR = 7'h09,
  parameter int         NUM_REGS = 64
) (
  input  logic       clk_12M,
  input  logic       rstn,
  input  logic       i2c_sclk,
  inout  wire        i2c_sdat,
  input  logic [7:0] rd_addr,
  output logic [7:0] rd_data,
  output logic       wr_strobe,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       busy
);
  localparam int         AW    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [8:0] NREGS = 9'(NUM_REGS);

  typedef enum logic [3:0] {
    IDLE, DEV, ACK_DEV, REG, ACK_REG, DATA, ACK_DATA, TX, RX_ACK, WAIT_STOP
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  scl_sync_q, scl_sync_d;
  logic [2:0]  sda_sync_q, sda_sync_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [6:0]  shift_q, shift_d;
  logic [7:0]  ptr_q, ptr_d;
  logic        phase_q, phase_d;
  logic        sda_oe_q, sda_oe_d;
  logic        wr_strobe_q, wr_strobe_d;
  logic [7:0]  wr_addr_q, wr_addr_d;
  logic [7:0]  wr_data_q, wr_data_d;
  logic [7:0]  rd_data_q, rd_data_d;
  logic        busy_q, busy_d;
  logic [7:0]  regfile_q [NUM_REGS];
  logic        reg_we;
  logic [7:0]  byte_rx;
  logic        scl, sda, scl_rise, scl_fall, start_det, stop_det;
`ifdef I2C_SLV_READ_EN
  logic        rw_q, rw_d;
  logic [6:0]  tx_shift_q, tx_shift_d;
  logic [7:0]  tx_next;
`endif

  function automatic logic in_range(input logic [7:0] a);
    return {1'b0, a} < NREGS;
  endfunction

  function automatic logic [7:0] rf_read(input logic [7:0] a);
    return in_range(a) ? regfile_q[a[AW-1:0]] : 8'h00;
  endfunction

  assign scl       = scl_sync_q[1];
  assign sda       = sda_sync_q[1];
  assign scl_rise  = scl & ~scl_sync_q[2];
  assign scl_fall  = ~scl & scl_sync_q[2];
  assign start_det = scl & scl_sync_q[2] & sda_sync_q[2] & ~sda;
  assign stop_det  = scl & scl_sync_q[2] & ~sda_sync_q[2] & sda;
  assign byte_rx   = {shift_q, sda};

  always_comb begin
    state_d     = state_q;
    scl_sync_d  = {scl_sync_q[1:0], i2c_sclk};
    sda_sync_d  = {sda_sync_q[1:0], i2c_sdat};
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    ptr_d       = ptr_q;
    phase_d     = phase_q;
    sda_oe_d    = sda_oe_q;
    wr_strobe_d = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    reg_we      = 1'b0;
`ifdef I2C_SLV_READ_EN
    rw_d        = rw_q;
    tx_shift_d  = tx_shift_q;
    tx_next     = rf_read(ptr_q);
`endif
    if (start_det) begin
      state_d   = DEV;
      bit_cnt_d = 3'd0;
      phase_d   = 1'b0;
      sda_oe_d  = 1'b0;
    end else if (stop_det) begin
      state_d   = IDLE;
      bit_cnt_d = 3'd0;
      phase_d   = 1'b0;
      sda_oe_d  = 1'b0;
    end else begin
      case (state_q)
        DEV, REG, DATA: begin
          if (scl_rise) begin
            shift_d   = byte_rx[6:0];
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              phase_d = 1'b0;
              case (state_q)
                DEV: begin
                  if (byte_rx == {DEV_ADDR, 1'b0}) begin
                    state_d = ACK_DEV;
`ifdef I2C_SLV_READ_EN
                    rw_d    = 1'b0;
                  end else if (byte_rx == {DEV_ADDR, 1'b1}) begin
                    state_d = ACK_DEV;
                    rw_d    = 1'b1;
`endif
                  end else begin
                    state_d = WAIT_STOP;
                  end
                end
                REG: begin
                  ptr_d   = byte_rx;
                  state_d = ACK_REG;
                end
                default: begin
                  if (in_range(ptr_q)) begin
                    reg_we      = 1'b1;
                    wr_strobe_d = 1'b1;
                    wr_addr_d   = ptr_q;
                    wr_data_d   = byte_rx;
                  end
                  ptr_d   = ptr_q + 8'd1;
                  state_d = ACK_DATA;
                end
              endcase
            end
          end
        end
        // ACK is driven for one full SCL period: first falling edge asserts, second releases.
        ACK_DEV, ACK_REG, ACK_DATA: begin
          if (scl_fall) begin
            if (!phase_q) begin
              sda_oe_d = 1'b1;
              phase_d  = 1'b1;
            end else begin
              sda_oe_d = 1'b0;
              phase_d  = 1'b0;
              state_d  = (state_q == ACK_DEV) ? REG : DATA;
`ifdef I2C_SLV_READ_EN
              if (state_q == ACK_DEV && rw_q) begin
                state_d    = TX;
                tx_shift_d = tx_next[6:0];
                sda_oe_d   = ~tx_next[7];
              end
`endif
            end
          end
        end
`ifdef I2C_SLV_READ_EN
        TX: begin
          if (scl_rise) begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) phase_d = 1'b1;
          end else if (scl_fall) begin
            if (phase_q) begin
              sda_oe_d = 1'b0;
              phase_d  = 1'b0;
              state_d  = RX_ACK;
            end else begin
              sda_oe_d   = ~tx_shift_q[6];
              tx_shift_d = {tx_shift_q[5:0], 1'b0};
            end
          end
        end
        RX_ACK: begin
          if (scl_rise) begin
            if (sda) begin
              state_d = WAIT_STOP;
            end else begin
              ptr_d   = ptr_q + 8'd1;
              phase_d = 1'b1;
            end
          end else if (scl_fall && phase_q) begin
            phase_d    = 1'b0;
            state_d    = TX;
            tx_shift_d = tx_next[6:0];
            sda_oe_d   = ~tx_next[7];
          end
        end
`endif
        default: ;
      endcase
    end
    busy_d    = (state_d != IDLE);
    rd_data_d = rf_read(rd_addr);
    if (reg_we && (rd_addr == ptr_q)) rd_data_d = byte_rx;
  end

  always_ff @(posedge clk_12M or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      scl_sync_q  <= 3'b111;
      sda_sync_q  <= 3'b111;
      bit_cnt_q   <= 3'd0;
      shift_q     <= 7'd0;
      ptr_q       <= 8'd0;
      phase_q     <= 1'b0;
      sda_oe_q    <= 1'b0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= 8'd0;
      wr_data_q   <= 8'd0;
      rd_data_q   <= 8'd0;
      busy_q      <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) regfile_q[i] <= 8'd0;
`ifdef I2C_SLV_READ_EN
      rw_q        <= 1'b0;
      tx_shift_q  <= 7'd0;
`endif
    end else begin
      state_q     <= state_d;
      scl_sync_q  <= scl_sync_d;
      sda_sync_q  <= sda_sync_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      ptr_q       <= ptr_d;
      phase_q     <= phase_d;
      sda_oe_q    <= sda_oe_d;
      wr_strobe_q <= wr_strobe_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      rd_data_q   <= rd_data_d;
      busy_q      <= busy_d;
      if (reg_we) regfile_q[ptr_q[AW-1:0]] <= byte_rx;
`ifdef I2C_SLV_READ_EN
      rw_q        <= rw_d;
      tx_shift_q  <= tx_shift_d;
`endif
    end
  end

  assign i2c_sdat  = sda_oe_q ? 1'b0 : 1'bz;
  assign rd_data   = rd_data_q;
  assign wr_strobe = wr_strobe_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_i2c_slave_reg.sv
// Bench for i2c_slave_reg: bit-banged 100 kHz master, directed scenarios plus random bursts
// checked against a byte-level register-file model.
`timescale 1ns/1ps
module tb_i2c_slave_reg;
  localparam logic [6:0] DEV   = 7'h09;
  localparam int         NREGS = 64;
  localparam time        Q     = 2500;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       scl = 1'b1;
  logic       m_low = 1'b0;
  logic [7:0] rd_addr = 8'h00;
  logic [7:0] rd_data, wr_addr, wr_data;
  logic       wr_strobe, busy;
  wire        sda_bus;

  pullup (sda_bus);
  assign sda_bus = m_low ? 1'b0 : 1'bz;

  always #41.667 clk = ~clk;

  i2c_slave_reg #(.DEV_ADDR(DEV), .NUM_REGS(NREGS)) dut (
    .clk_12M  (clk),
    .rstn     (rstn),
    .i2c_sclk (scl),
    .i2c_sdat (sda_bus),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .wr_strobe(wr_strobe),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .busy     (busy)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int strobe_cnt = 0;

  always @(negedge clk) if (wr_strobe === 1'b1) strobe_cnt++;

  // reference model
  logic [7:0] mregs [256];
  logic [7:0] mptr, m_wa, m_wd;
  int         m_stores = 0;
  logic [7:0] tx_buf  [8];
  logic       ack_buf [8];
  logic       exp_ack [8];
  logic       busy_mid;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] m_rd(input logic [7:0] a);
    return (int'(a) < NREGS) ? mregs[a] : 8'h00;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 256; i++) mregs[i] = 8'h00;
    mptr = 8'h00; m_wa = 8'h00; m_wd = 8'h00;
  endtask

  task automatic model_write(input int n);
    logic ok;
    ok = (tx_buf[0] == {DEV, 1'b0});
    for (int i = 0; i < n; i++) exp_ack[i] = ok;
    if (ok && n > 1) begin
      mptr = tx_buf[1];
      for (int i = 2; i < n; i++) begin
        if (int'(mptr) < NREGS) begin
          mregs[mptr] = tx_buf[i];
          m_wa = mptr;
          m_wd = tx_buf[i];
          m_stores++;
        end
        mptr = 8'((int'(mptr) + 1) % 256);
      end
    end
  endtask

  task automatic i2c_start();
    m_low = 1'b0; #Q; scl = 1'b1; #Q; m_low = 1'b1; #Q; scl = 1'b0; #Q;
  endtask

  task automatic i2c_stop();
    m_low = 1'b1; #Q; scl = 1'b1; #Q; m_low = 1'b0; #(2*Q);
  endtask

  task automatic write_bit(input logic b);
    m_low = ~b; #Q; scl = 1'b1; #(2*Q); scl = 1'b0; #Q;
  endtask

  task automatic read_bit(output logic b);
    m_low = 1'b0; #Q; scl = 1'b1; #Q; b = sda_bus; #Q; scl = 1'b0; #Q;
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) write_bit(b[i]);
    read_bit(s);
    ack = ~s;
  endtask

  task automatic read_byte(input logic ack, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      read_bit(s);
      d[i] = s;
    end
    write_bit(~ack);
  endtask

  task automatic do_write(input int n);
    i2c_start();
    for (int i = 0; i < n; i++) write_byte(tx_buf[i], ack_buf[i]);
    busy_mid = busy;
    i2c_stop();
  endtask

  task automatic rd_reg(input logic [7:0] a, output logic [7:0] d);
    @(negedge clk); rd_addr = a;
    @(negedge clk); d = rd_data;
  endtask

  task automatic check_regs(input string tag);
    logic [7:0] d;
    for (int a = 0; a < 256; a++) begin
      rd_reg(8'(a), d);
      check_val($sformatf("%s_reg%02h", tag, a), d, m_rd(8'(a)));
    end
  endtask

  task automatic check_write(input string tag, input int n, input int s0, input int ms0);
    for (int i = 0; i < n; i++) check_val($sformatf("%s_ack%0d", tag, i), ack_buf[i], exp_ack[i]);
    @(negedge clk);
    check_val({tag, "_strobes"}, strobe_cnt - s0, m_stores - ms0);
    check_val({tag, "_wr_addr"}, wr_addr, m_wa);
    check_val({tag, "_wr_data"}, wr_data, m_wd);
    check_val({tag, "_busy_mid"}, busy_mid, 1'b1);
    check_val({tag, "_busy_end"}, busy, 1'b0);
  endtask

  initial begin
    #20ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int s0, ms0, n, sel;
    logic a0, a1, a2;
    logic [7:0] d0, d1, bad;

    model_reset();
    repeat (4) @(negedge clk);
    check_val("rst_busy", busy, 1'b0);
    check_val("rst_strobe", wr_strobe, 1'b0);
    check_val("rst_wr_addr", wr_addr, 8'h00);
    check_val("rst_wr_data", wr_data, 8'h00);
    check_val("rst_rd_data", rd_data, 8'h00);
    check_val("rst_sda", sda_bus, 1'b1);
    rstn = 1'b1;
    repeat (4) @(negedge clk);
    check_regs("rst");

    // basic single-byte write
    tx_buf[0] = 8'h12; tx_buf[1] = 8'h20; tx_buf[2] = 8'h2A;
    s0 = strobe_cnt; ms0 = m_stores;
    do_write(3); model_write(3);
    check_write("w1", 3, s0, ms0);
    rd_reg(8'h20, d0);
    check_val("w1_rd20", d0, 8'h2A);

    // wrong address: NACK and ignore until STOP
    tx_buf[0] = 8'h14; tx_buf[1] = 8'h12;
    s0 = strobe_cnt; ms0 = m_stores;
    do_write(2); model_write(2);
    check_write("nack", 2, s0, ms0);

    // burst across the top of the register file
    tx_buf[0] = 8'h12; tx_buf[1] = 8'h3E; tx_buf[2] = 8'h11; tx_buf[3] = 8'h22; tx_buf[4] = 8'h33;
    s0 = strobe_cnt; ms0 = m_stores;
    do_write(5); model_write(5);
    check_write("burst", 5, s0, ms0);
    check_val("burst_count", m_stores - ms0, 2);
    check_regs("burst");

    // reset in the middle of a write, bus activity ignored until next START
    i2c_start();
    write_byte(8'h12, a0);
    write_byte(8'h30, a1);
    #Q; rstn = 1'b0; #10;
    check_val("mid_rst_busy", busy, 1'b0);
    check_val("mid_rst_wr_addr", wr_addr, 8'h00);
    check_val("mid_rst_wr_data", wr_data, 8'h00);
    check_val("mid_rst_rd_data", rd_data, 8'h00);
    check_val("mid_rst_sda", sda_bus, 1'b1);
    model_reset();
    @(negedge clk); rstn = 1'b1;
    s0 = strobe_cnt;
    write_byte(8'h77, a2);
    check_val("after_rst_ignored_ack", a2, 1'b0);
    check_val("after_rst_busy", busy, 1'b0);
    i2c_stop();
    check_val("after_rst_strobes", strobe_cnt - s0, 0);
    tx_buf[0] = 8'h12; tx_buf[1] = 8'h05; tx_buf[2] = 8'h08;
    s0 = strobe_cnt; ms0 = m_stores;
    do_write(3); model_write(3);
    check_write("post_rst", 3, s0, ms0);
    check_regs("post_rst");

    // repeated START with read address
    tx_buf[0] = 8'h12; tx_buf[1] = 8'h03; tx_buf[2] = 8'hC3; tx_buf[3] = 8'h3C;
    s0 = strobe_cnt; ms0 = m_stores;
    do_write(4); model_write(4);
    check_write("pre_rd", 4, s0, ms0);
`ifdef I2C_SLV_READ_EN
    for (int k = 0; k < 2; k++) begin
      tx_buf[0] = 8'h12; tx_buf[1] = (k == 0) ? 8'h03 : 8'h3F;
      i2c_start();
      write_byte(tx_buf[0], a0);
      write_byte(tx_buf[1], a1);
      model_write(2);
      i2c_start();
      write_byte(8'h13, a2);
      read_byte(1'b1, d0);
      read_byte(1'b0, d1);
      i2c_stop();
      check_val($sformatf("rd%0d_ack_dev", k), a2, 1'b1);
      check_val($sformatf("rd%0d_byte0", k), d0, m_rd(mptr));
      check_val($sformatf("rd%0d_byte1", k), d1, m_rd(8'(int'(mptr) + 1)));
      check_val($sformatf("rd%0d_busy_end", k), busy, 1'b0);
    end
`else
    i2c_start();
    write_byte(8'h12, a0);
    write_byte(8'h03, a1);
    i2c_start();
    write_byte(8'h13, a2);
    busy_mid = busy;
    i2c_stop();
    check_val("rd_ack_w", a0 & a1, 1'b1);
    check_val("rd_nack_dev", a2, 1'b0);
    check_val("rd_busy_mid", busy_mid, 1'b1);
    check_val("rd_busy_end", busy, 1'b0);
`endif

    // random bursts, some to a foreign address, some near boundaries
    for (int t = 0; t < 5; t++) begin
      n   = 2 + $urandom_range(1, 3);
      sel = $urandom_range(0, 4);
      bad = {7'($urandom_range(0, 127)), 1'b0};
      if (bad == 8'h12) bad = 8'h16;
      tx_buf[0] = (sel == 0) ? bad : 8'h12;
      tx_buf[1] = (sel == 1) ? 8'h3E : (sel == 2) ? 8'hFE : 8'($urandom_range(0, 255));
      for (int i = 2; i < n; i++) tx_buf[i] = 8'($urandom_range(0, 255));
      s0 = strobe_cnt; ms0 = m_stores;
      do_write(n); model_write(n);
      check_write($sformatf("rnd%0d", t), n, s0, ms0);
      check_regs($sformatf("rnd%0d", t));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/i2c_slave_reg.md
I2C_SLAVE_REG -- requirements
Module: i2c_slave_reg

Interface
REQ-001 SHALL have parameter DEV_ADDR, default 7'h09, meaning 7-bit device address (write byte 8'h12, read byte 8'h13).
REQ-002 SHALL have parameter NUM_REGS, default 64, meaning register-file depth in bytes (≤256).
REQ-003 SHALL have port clk_12M  input  1  meaning the only clock, 12 MHz.
REQ-004 SHALL have port rstn  input  1  meaning reset, asynchronous, active-low.
REQ-005 SHALL have port i2c_sclk  input  1  meaning I2C clock from master, 100 kHz.
REQ-006 SHALL have port i2c_sdat  inout  1  meaning I2C data; driven only low (open-drain), else high-Z.
REQ-007 SHALL have port rd_addr  input  8  meaning local read-back address.
REQ-008 SHALL have port rd_data  output  8  meaning regfile[rd_addr], registered.
REQ-009 SHALL have port wr_strobe  output  1  meaning one-cycle pulse per stored data byte.
REQ-010 SHALL have port wr_addr  output  8  meaning register address of the last stored byte.
REQ-011 SHALL have port wr_data  output  8  meaning value of the last stored byte.
REQ-012 SHALL have port busy  output  1  meaning high from START until STOP/abandon.

Function
REQ-013 SHALL pass i2c_sclk and i2c_sdat through 2-flop synchronizers; edges detected on synchronized values.
REQ-014 SHALL detect START as SDA falling while SCL high and STOP as SDA rising while SCL high, in any state.
REQ-015 SHALL use states IDLE, DEV, ACK_DEV, REG, ACK_REG, DATA, ACK_DATA, TX, RX_ACK, WAIT_STOP.
REQ-016 SHALL enter DEV on START from any state (repeated START included) and IDLE on STOP from any state.
REQ-017 SHALL shift bits MSB first on synchronized SCL rising edges; bit counter 0..7 clears on START.
REQ-018 SHALL, in DEV after 8 bits: match of {DEV_ADDR,0} -> ACK_DEV; mismatch -> release SDA, go WAIT_STOP.
REQ-019 SHALL drive SDA low for ACK from the SCL falling edge after bit 8 until the next SCL falling edge.
REQ-020 SHALL go ACK_DEV->REG, load byte into pointer in REG, ACK_REG->DATA.
REQ-021 SHALL in DATA after 8 bits: if pointer<NUM_REGS write regfile[pointer], pulse wr_strobe one clk_12M cycle after the 8th rising edge is detected, update wr_addr/wr_data; always ACK.
REQ-022 SHALL not write or strobe when pointer≥NUM_REGS, but still ACK.
REQ-023 SHALL increment pointer (8-bit, wraps 8'hFF->8'h00) after each data byte; ACK_DATA->DATA for burst writes.
REQ-024 SHALL register rd_data one cycle after rd_addr; rd_addr≥NUM_REGS returns 8'h00; same-cycle write visible the next cycle.
REQ-025 SHALL keep busy high in every state except IDLE.

Reset
REQ-026 SHALL on rstn low immediately: state IDLE, SDA released, regfile all 8'h00, pointer 0, wr_strobe 0, wr_addr 0, wr_data 0, rd_data 0, busy 0.
REQ-027 SHALL, when rstn deasserts mid-transaction, ignore bus activity until the next START.

Configuration
REQ-028 SHALL support macro I2C_SLV_READ_EN.
REQ-029 With I2C_SLV_READ_EN: {DEV_ADDR,1} is ACKed; TX drives regfile[pointer] (8'h00 if ≥NUM_REGS) MSB first, SDA changed on SCL falling; RX_ACK samples master bit: ACK -> pointer+1, next TX; NACK -> WAIT_STOP.
REQ-030 Without I2C_SLV_READ_EN: {DEV_ADDR,1} is NACKed and goes WAIT_STOP; TX/RX_ACK logic absent.

Verification
REQ-031 Write 12/20/2A at 100 kHz -> ACK on all 3 bytes, one wr_strobe, wr_addr=8'h20, wr_data=8'h2A, rd_addr=8'h20 gives 8'h2A, busy drops after STOP.
REQ-032 Address byte 8'h14 -> no ACK (SDA high on 9th clock), no strobe, state WAIT_STOP until STOP.
REQ-033 Burst 12/3E/11/22/33 -> regs 0x3E=11, 0x3F=22 stored, 0x40 not stored but ACKed, two strobes.
REQ-034 rstn pulse low after REG byte, then new write 12/05/08 -> all regs 0 except 0x05=8'h08.
REQ-035 With I2C_SLV_READ_EN: write pointer 8'h03 then repeated START 13, master ACK then NACK -> bytes regfile[3], regfile[4] returned; without macro 13 is NACKed.
